// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with a RAW-hazard interlock for a non-forwarding RV32I pipeline.
// Latency: 1 cycle from id_* to ex_*; o_hazard_stall is combinational from id_* and the history.
// Backpressure: i_stall freezes this stage, history included; o_hazard_stall holds IF/ID while bubbles issue.
//
// Ports:
//   i_clk, i_rst         clock and synchronous active-high reset
//   i_stall, i_flush     downstream hold / redirect kill of the ID instruction
//   id_*                 decoded instruction from ID (valid, pc, operands, control)
//   ex_*                 registered copies of the id_* fields that drive EX
//   o_hazard_stall       IF/ID must hold its current instruction this cycle
//   o_bubble_cnt         hazard-bubble counter, present only with ID_EX_PERF_EN defined
//
// Optional feature macro: ID_EX_PERF_EN (adds o_bubble_cnt).
module id_ex_stage #(
  parameter int HAZARD_DEPTH = 3,
  parameter int ALU_OP_W     = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                id_valid,
  input  logic [31:0]         id_pc,
  input  logic [4:0]          id_rs1_addr,
  input  logic [4:0]          id_rs2_addr,
  input  logic [31:0]         id_rs1_data,
  input  logic [31:0]         id_rs2_data,
  input  logic [31:0]         id_imm,
  input  logic [4:0]          id_rd_addr,
  input  logic                id_opa_sel,
  input  logic                id_opb_sel,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_rd_wren,
  input  logic                id_mem_wren,
  input  logic [1:0]          id_wb_sel,
  output logic                ex_valid,
  output logic [31:0]         ex_pc,
  output logic [31:0]         ex_rs1_data,
  output logic [31:0]         ex_rs2_data,
  output logic [31:0]         ex_imm,
  output logic [4:0]          ex_rd_addr,
  output logic                ex_opa_sel,
  output logic                ex_opb_sel,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_rd_wren,
  output logic                ex_mem_wren,
  output logic [1:0]          ex_wb_sel,
  output logic                o_hazard_stall
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]         o_bubble_cnt
`endif
);

  // Everything the EX stage consumes, carried as one packed word.
  typedef struct packed {
    logic                valid;
    logic [31:0]         pc;
    logic [31:0]         rs1_data;
    logic [31:0]         rs2_data;
    logic [31:0]         imm;
    logic [4:0]          rd_addr;
    logic                opa_sel;
    logic                opb_sel;
    logic [ALU_OP_W-1:0] alu_op;
    logic                rd_wren;
    logic                mem_wren;
    logic [1:0]          wb_sel;
  } ex_ctl_t;

  ex_ctl_t id_d;
  ex_ctl_t ex_d;
  ex_ctl_t ex_q;

  // In-flight destination history. Entry 0 mirrors the instruction now in EX,
  // higher entries are the instructions that followed it down the pipe.
  logic [HAZARD_DEPTH-1:0] hist_vld;
  logic [4:0]              hist_rd [HAZARD_DEPTH];

  logic rs1_used;
  logic rs2_used;
  logic hist_hit;
  logic hazard;
  logic advance;
  logic push_vld;

  assign id_d = '{
    valid:    id_valid,
    pc:       id_pc,
    rs1_data: id_rs1_data,
    rs2_data: id_rs2_data,
    imm:      id_imm,
    rd_addr:  id_rd_addr,
    opa_sel:  id_opa_sel,
    opb_sel:  id_opb_sel,
    alu_op:   id_alu_op,
    rd_wren:  id_rd_wren,
    mem_wren: id_mem_wren,
    wb_sel:   id_wb_sel
  };

  // Source-use decode. Stores read rs2 even though operand B is the immediate.
  // x0 reads are constant zero, so they can never depend on a producer.
  always_comb begin
    rs1_used = (id_opa_sel == 1'b0) && (id_rs1_addr != 5'd0);
    rs2_used = ((id_opb_sel == 1'b0) || id_mem_wren) && (id_rs2_addr != 5'd0);
  end

  always_comb begin
    hist_hit = 1'b0;
    for (int i = 0; i < HAZARD_DEPTH; i++) begin
      if (hist_vld[i] &&
          ((rs1_used && (hist_rd[i] == id_rs1_addr)) ||
           (rs2_used && (hist_rd[i] == id_rs2_addr)))) begin
        hist_hit = 1'b1;
      end
    end
  end

  assign hazard         = id_valid && hist_hit;
  // A flush kills the ID instruction, so there is nothing left to hold.
  assign o_hazard_stall = hazard && !i_flush;

  // A flush overrides a downstream stall; otherwise a stall freezes the stage.
  assign advance = i_flush || !i_stall;

  // Next EX contents whenever the stage advances: a bubble on flush, on hazard,
  // or when ID is empty; otherwise the ID instruction itself.
  always_comb begin
    ex_d = '0;
    if (!i_flush && !hazard && id_valid) begin
      ex_d = id_d;
    end
  end

  assign push_vld = ex_d.valid && ex_d.rd_wren;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_q     <= '0;
      hist_vld <= '0;
      for (int i = 0; i < HAZARD_DEPTH; i++) begin
        hist_rd[i] <= 5'd0;
      end
    end else if (advance) begin
      ex_q        <= ex_d;
      hist_vld[0] <= push_vld;
      hist_rd[0]  <= ex_d.rd_addr;
      for (int i = 1; i < HAZARD_DEPTH; i++) begin
        hist_vld[i] <= hist_vld[i-1];
        hist_rd[i]  <= hist_rd[i-1];
      end
    end
  end

`ifdef ID_EX_PERF_EN
  // Counts only interlock bubbles; flush bubbles and stalled cycles are excluded.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bubble_cnt <= 32'd0;
    end else if (!i_flush && !i_stall && hazard && (o_bubble_cnt != 32'hFFFF_FFFF)) begin
      o_bubble_cnt <= o_bubble_cnt + 32'd1;
    end
  end
`endif

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rd_addr  = ex_q.rd_addr;
  assign ex_opa_sel  = ex_q.opa_sel;
  assign ex_opb_sel  = ex_q.opb_sel;
  assign ex_alu_op   = ex_q.alu_op;
  assign ex_rd_wren  = ex_q.rd_wren;
  assign ex_mem_wren = ex_q.mem_wren;
  assign ex_wb_sel   = ex_q.wb_sel;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed interlock scenarios followed by randomized traffic,
// checked against a per-register "cycles until written back" scoreboard.
// Summary line: TB_RESULT checks=<n> failures=<n>.
module tb_id_ex_stage;

  localparam int HD = 3;
  localparam int AW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst, i_stall, i_flush;
  logic          id_valid;
  logic [31:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]    id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic          id_opa_sel, id_opb_sel, id_rd_wren, id_mem_wren;
  logic [AW-1:0] id_alu_op;
  logic [1:0]    id_wb_sel;
  logic          ex_valid;
  logic [31:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]    ex_rd_addr;
  logic          ex_opa_sel, ex_opb_sel, ex_rd_wren, ex_mem_wren;
  logic [AW-1:0] ex_alu_op;
  logic [1:0]    ex_wb_sel;
  logic          o_hazard_stall;
`ifdef ID_EX_PERF_EN
  logic [31:0]   o_bubble_cnt;
`endif

  id_ex_stage #(.HAZARD_DEPTH(HD), .ALU_OP_W(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd_addr(id_rd_addr),
    .id_opa_sel(id_opa_sel), .id_opb_sel(id_opb_sel), .id_alu_op(id_alu_op),
    .id_rd_wren(id_rd_wren), .id_mem_wren(id_mem_wren), .id_wb_sel(id_wb_sel),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rd_addr(ex_rd_addr),
    .ex_opa_sel(ex_opa_sel), .ex_opb_sel(ex_opb_sel), .ex_alu_op(ex_alu_op),
    .ex_rd_wren(ex_rd_wren), .ex_mem_wren(ex_mem_wren), .ex_wb_sel(ex_wb_sel),
    .o_hazard_stall(o_hazard_stall)
`ifdef ID_EX_PERF_EN
    , .o_bubble_cnt(o_bubble_cnt)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: busy[r] = number of further pipeline advances before a
  // write to r has been written back; a source is blocked while it is nonzero.
  int            busy [32];
  logic [143:0]  m_ex;
  logic [31:0]   m_cnt;
  logic          s_hz;   // DUT o_hazard_stall sampled in the last tick

  function automatic logic [143:0] id_bundle();
    return {id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rd_addr,
            id_opa_sel, id_opb_sel, id_alu_op, id_rd_wren, id_mem_wren, id_wb_sel};
  endfunction

  function automatic logic [143:0] ex_bundle();
    return {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd_addr,
            ex_opa_sel, ex_opb_sel, ex_alu_op, ex_rd_wren, ex_mem_wren, ex_wb_sel};
  endfunction

  function automatic logic m_hazard();
    logic h = 1'b0;
    if (id_valid) begin
      if (!id_opa_sel && id_rs1_addr != 0 && busy[id_rs1_addr] > 0) h = 1'b1;
      if ((!id_opb_sel || id_mem_wren) && id_rs2_addr != 0 && busy[id_rs2_addr] > 0) h = 1'b1;
    end
    return h;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 32; r++) busy[r] = 0;
    m_ex  = '0;
    m_cnt = '0;
  endtask

  task automatic m_advance();
    for (int r = 0; r < 32; r++) if (busy[r] > 0) busy[r]--;
  endtask

  task automatic m_edge(input logic hz);
    if (i_rst) begin
      m_clear();
    end else if (i_flush) begin
      m_ex = '0;
      m_advance();
    end else if (i_stall) begin
      // everything holds
    end else if (hz) begin
      m_ex = '0;
      m_advance();
      if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
    end else begin
      m_ex = id_valid ? id_bundle() : '0;
      m_advance();
      if (id_valid && id_rd_wren && id_rd_addr != 0) busy[id_rd_addr] = HD;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge,
  // leave the bench 1 time unit after the edge ready for new inputs.
  task automatic tick();
    logic hz;
    @(negedge i_clk);
    hz   = m_hazard();
    s_hz = o_hazard_stall;
    check("hazard_stall", {143'd0, o_hazard_stall}, {143'd0, hz && !i_flush});
    check("ex_fields", ex_bundle(), m_ex);
`ifdef ID_EX_PERF_EN
    check("bubble_cnt", {112'd0, o_bubble_cnt}, {112'd0, m_cnt});
`endif
    @(posedge i_clk);
    m_edge(hz);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic opa,
                           input logic opb, input logic wr, input logic st);
    id_valid    = v;       id_pc       = pc;
    id_rs1_addr = rs1;     id_rs2_addr = rs2;   id_rd_addr = rd;
    id_opa_sel  = opa;     id_opb_sel  = opb;
    id_rd_wren  = wr;      id_mem_wren = st;
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_alu_op   = AW'($urandom_range(0, 15));
    id_wb_sel   = 2'($urandom_range(0, 3));
  endtask

  // Keep presenting the held consumer until it leaves ID; returns hazard cycles seen.
  task automatic drain(output int stalls);
    bit done = 0;
    stalls = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      tick();
      if (s_hz) stalls++;
      else done = 1;
    end
    if (!done) stalls = 99;
  endtask

  initial begin
    int          nst;
    logic [31:0] cnt0;
    logic        hold;

    i_rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
    set_instr(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge i_clk);
    #1;
    m_clear();
    check("reset_ex_valid", {143'd0, ex_valid}, 144'd0);
    check("reset_ex_all", ex_bundle(), 144'd0);
    i_rst = 1'b0;

    // addi x5,x0,1 ; add x6,x5,x5 -> three interlock cycles
    set_instr(1'b1, 32'h100, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    check("reset_hazard", {143'd0, o_hazard_stall}, 144'd0);
    tick();
    set_instr(1'b1, 32'h104, 5'd5, 5'd5, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    drain(nst);
    check("raw_stall_cycles", 144'(nst), 144'd3);
    check("raw_consumer_pc", {112'd0, ex_pc}, {112'd0, 32'h104});
    check("raw_consumer_valid", {143'd0, ex_valid}, 144'd1);
`ifdef ID_EX_PERF_EN
    check("raw_bubble_cnt", {112'd0, o_bubble_cnt}, 144'd3);
`endif

    // write x1, then auipc x7 with rs1 field = 1: operand A is pc, no stall
    set_instr(1'b1, 32'h200, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_instr(1'b1, 32'h204, 5'd1, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    check("auipc_no_stall", {143'd0, s_hz}, 144'd0);

    // producer to x0, then consumer of x0: back-to-back issue
    set_instr(1'b1, 32'h300, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check("x0_prod_valid", {143'd0, ex_valid}, 144'd1);
    set_instr(1'b1, 32'h304, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check("x0_cons_no_stall", {143'd0, s_hz}, 144'd0);
    check("x0_cons_valid", {143'd0, ex_valid}, 144'd1);

    // flush in the same cycle as a hazard
    set_instr(1'b1, 32'h400, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
`ifdef ID_EX_PERF_EN
    cnt0 = o_bubble_cnt;
`else
    cnt0 = 32'd0;
`endif
    set_instr(1'b1, 32'h404, 5'd5, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("flush_hz_stall", {143'd0, s_hz}, 144'd0);
    check("flush_ex_valid", {143'd0, ex_valid}, 144'd0);
`ifdef ID_EX_PERF_EN
    check("flush_cnt_same", {112'd0, o_bubble_cnt}, {112'd0, cnt0});
`endif
    repeat (3) tick();

    // stall held 4 cycles while a hazard is pending
    set_instr(1'b1, 32'h500, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_instr(1'b1, 32'h504, 5'd0, 5'd9, 5'd10, 1'b0, 1'b1, 1'b0, 1'b1);
    i_stall = 1'b1;
    nst = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (s_hz) nst++;
    end
    check("stall_hz_held", 144'(nst), 144'd4);
    check("stall_ex_frozen", {112'd0, ex_pc}, {112'd0, 32'h500});
    i_stall = 1'b0;
    drain(nst);
    check("stall_release_cycles", 144'(nst), 144'd3);
    check("stall_consumer_pc", {112'd0, ex_pc}, {112'd0, 32'h504});

    // reset pulsed during an interlock
    set_instr(1'b1, 32'h600, 5'd0, 5'd0, 5'd11, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_instr(1'b1, 32'h604, 5'd11, 5'd0, 5'd12, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    check("pre_rst_hz", {143'd0, s_hz}, 144'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("rst_ex_all", ex_bundle(), 144'd0);
    check("rst_hz_clear", {143'd0, o_hazard_stall}, 144'd0);
    tick();
    check("rst_consumer_issued", {112'd0, ex_pc}, {112'd0, 32'h604});

    // randomized traffic; IF/ID holds its instruction while stalled
    hold = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      i_rst   = ($urandom_range(0, 99) < 1);
      i_flush = ($urandom_range(0, 99) < 8);
      i_stall = ($urandom_range(0, 99) < 15);
      if (!hold) begin
        set_instr($urandom_range(0, 99) < 85, $urandom,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20);
      end
      tick();
      hold = (s_hz || i_stall) && !i_flush;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
